// File: rtl/d_ff_delay_line.sv
// WIDTH-bit, DEPTH-stage stallable delay line with per-stage valid tags,
// synchronous flush, a combinational tap read port and an occupancy counter.
module d_ff_delay_line #(
   parameter int unsigned      WIDTH       = 8,
   parameter int unsigned      DEPTH       = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   localparam int unsigned     TAPW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned     CNTW        = ($clog2(DEPTH + 1) > 0) ? $clog2(DEPTH + 1) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             flush,
   input  logic [WIDTH-1:0] d,
   input  logic             d_valid,
   input  logic [TAPW-1:0]  tap_sel,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   output logic [WIDTH-1:0] tap_out,
   output logic             tap_valid,
   output logic [CNTW-1:0]  count
);

   logic [WIDTH-1:0] r_stage [DEPTH];
   logic [DEPTH-1:0] r_vld;
   logic [CNTW-1:0]  r_count;

   logic [CNTW-1:0]  w_count_nxt;
   logic [WIDTH-1:0] w_tap_out;
   logic             w_tap_valid;

   // Entry and exit on the same edge cancel, keeping count == popcount(r_vld).
   always_comb begin
      w_count_nxt = r_count + CNTW'(d_valid) - CNTW'(r_vld[DEPTH-1]);
   end

   // Stage storage: flush beats enable, otherwise hold.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            r_stage[k] <= RESET_VALUE;
         end
         r_vld   <= '0;
         r_count <= '0;
      end else if (flush) begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            r_stage[k] <= RESET_VALUE;
         end
         r_vld   <= '0;
         r_count <= '0;
      end else if (en) begin
         r_stage[0] <= d;
         r_vld[0]   <= d_valid;
         for (int unsigned k = 1; k < DEPTH; k++) begin
            r_stage[k] <= r_stage[k-1];
            r_vld[k]   <= r_vld[k-1];
         end
         r_count <= w_count_nxt;
      end
   end

   // Tap mux; out-of-range selects read as an empty stage.
   always_comb begin
      w_tap_out   = RESET_VALUE;
      w_tap_valid = 1'b0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         if ((DEPTH == 1) || (tap_sel == TAPW'(k))) begin
            w_tap_out   = r_stage[k];
            w_tap_valid = r_vld[k];
         end
      end
   end

   assign out       = r_stage[DEPTH-1];
   assign out_valid = r_vld[DEPTH-1];
   assign tap_out   = w_tap_out;
   assign tap_valid = w_tap_valid;
   assign count     = r_count;

endmodule

// File: tb/tb_d_ff_delay_line.sv
// Directed self-checking bench for d_ff_delay_line (DEPTH=4 main, DEPTH=3 tap range).
module tb_d_ff_delay_line;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       flush;
   logic [7:0] d;
   logic       dv;
   logic [1:0] tap_sel;

   logic [7:0] out4, tap4;
   logic       ov4, tv4;
   logic [2:0] cnt4;
   logic [7:0] out3, tap3;
   logic       ov3, tv3;
   logic [1:0] cnt3;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] bub_d   [8] = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67};
   logic       bub_v   [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
   logic [7:0] bub_out [8] = '{8'h22, 8'h33, 8'h44, 8'h60, 8'h61, 8'h62, 8'h63, 8'h64};
   logic       bub_ov  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
   logic [2:0] bub_cnt [8] = '{3'd4, 3'd3, 3'd3, 3'd3, 3'd2, 3'd3, 3'd2, 3'd1};
   logic [7:0] tap_exp [4] = '{8'hA0, 8'hB0, 8'hC0, 8'hD0};
   logic [7:0] fill_d  [4] = '{8'hD0, 8'hC0, 8'hB0, 8'hA0};

   always #5 clk = ~clk;

   d_ff_delay_line #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(8'h00)) u_dut4 (
      .clk(clk), .reset(reset), .en(en), .flush(flush), .d(d), .d_valid(dv),
      .tap_sel(tap_sel), .out(out4), .out_valid(ov4), .tap_out(tap4),
      .tap_valid(tv4), .count(cnt4)
   );

   d_ff_delay_line #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(8'h00)) u_dut3 (
      .clk(clk), .reset(reset), .en(en), .flush(flush), .d(d), .d_valid(dv),
      .tap_sel(tap_sel), .out(out3), .out_valid(ov3), .tap_out(tap3),
      .tap_valid(tv3), .count(cnt3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Drive one cycle of inputs and sample 1 time unit after the edge.
   task automatic cyc(input logic e, input logic f, input logic [7:0] dd, input logic v);
      en = e; flush = f; d = dd; dv = v;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; en = 1'b0; flush = 1'b0; d = 8'h00; dv = 1'b0; tap_sel = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out",  32'(out4), 32'h00);
      chk("rst_ov",   32'(ov4),  32'h0);
      chk("rst_cnt",  32'(cnt4), 32'h0);
      chk("rst_tapv", 32'(tv4),  32'h0);

      // Fill from empty
      reset = 1'b1;
      cyc(1'b1, 1'b0, 8'h11, 1'b1);
      chk("fill1_cnt", 32'(cnt4), 32'd1);
      chk("fill1_ov",  32'(ov4),  32'h0);
      chk("fill1_out", 32'(out4), 32'h00);
      cyc(1'b1, 1'b0, 8'h22, 1'b1);
      chk("fill2_cnt", 32'(cnt4), 32'd2);
      cyc(1'b1, 1'b0, 8'h33, 1'b1);
      chk("fill3_cnt", 32'(cnt4), 32'd3);
      chk("fill3_ov",  32'(ov4),  32'h0);
      cyc(1'b1, 1'b0, 8'h44, 1'b1);
      chk("fill4_cnt", 32'(cnt4), 32'd4);
      chk("fill4_out", 32'(out4), 32'h11);
      chk("fill4_ov",  32'(ov4),  32'h1);

      // Stall: two words in, three held cycles, then resume
      #2 reset = 1'b0;
      #1;
      chk("arst_cnt", 32'(cnt4), 32'd0);
      reset = 1'b1;
      tap_sel = 2'd1;
      cyc(1'b1, 1'b0, 8'h11, 1'b1);
      cyc(1'b1, 1'b0, 8'h22, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, 8'hE0 + 8'(i), 1'b1);
         chk("stall_cnt", 32'(cnt4), 32'd2);
         chk("stall_out", 32'(out4), 32'h00);
         chk("stall_tap", 32'(tap4), 32'h11);
      end
      cyc(1'b1, 1'b0, 8'h33, 1'b1);
      chk("resume3_ov", 32'(ov4), 32'h0);
      cyc(1'b1, 1'b0, 8'h44, 1'b1);
      chk("resume4_out", 32'(out4), 32'h11);
      chk("resume4_ov",  32'(ov4),  32'h1);

      // Bubbles streaming through a full line
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 1'b0, bub_d[i], bub_v[i]);
         chk("bub_out", 32'(out4), 32'(bub_out[i]));
         chk("bub_ov",  32'(ov4),  32'(bub_ov[i]));
         chk("bub_cnt", 32'(cnt4), 32'(bub_cnt[i]));
      end

      // Tap sweep with stage0..3 = A0,B0,C0,D0
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, fill_d[i], 1'b1);
      en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tap_sel = 2'(i);
         #1;
         chk("tap_data",  32'(tap4), 32'(tap_exp[i]));
         chk("tap_valid", 32'(tv4),  32'h1);
      end
      tap_sel = 2'd2;
      #1;
      chk("tap3_in",   32'(tap3), 32'hC0);
      tap_sel = 2'd3;
      #1;
      chk("tap3_oor",  32'(tap3), 32'h00);
      chk("tap3_oorv", 32'(tv3),  32'h0);
      chk("full_cnt",  32'(cnt4), 32'd4);

      // Flush beats enable and discards the incoming word
      tap_sel = 2'd0;
      cyc(1'b1, 1'b1, 8'h55, 1'b1);
      chk("flush_cnt",  32'(cnt4), 32'd0);
      chk("flush_out",  32'(out4), 32'h00);
      chk("flush_ov",   32'(ov4),  32'h0);
      chk("flush_tap0", 32'(tap4), 32'h00);
      chk("flush_tv0",  32'(tv4),  32'h0);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b0, 8'h00, 1'b0);
         chk("flush_drain", 32'(out4), 32'h00);
      end

      // Asynchronous reset between edges on a full line
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'(i + 1), 1'b1);
      chk("pre_arst_cnt", 32'(cnt4), 32'd4);
      chk("pre_arst_out", 32'(out4), 32'h01);
      en = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("arst_out",  32'(out4), 32'h00);
      chk("arst_tap",  32'(tap4), 32'h00);
      chk("arst_cnt2", 32'(cnt4), 32'd0);
      chk("arst_ov",   32'(ov4),  32'h0);
      reset = 1'b1;
      cyc(1'b1, 1'b0, 8'h77, 1'b1);
      chk("rel_tap0", 32'(tap4), 32'h77);
      chk("rel_tv0",  32'(tv4),  32'h1);
      chk("rel_cnt",  32'(cnt4), 32'd1);
      chk("rel_out",  32'(out4), 32'h00);
      en = 1'b0;
      tap_sel = 2'd1;
      #1;
      chk("rel_tap1", 32'(tap4), 32'h00);
      chk("rel_tv1",  32'(tv4),  32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
